ifu_fetch: RTL and testbench

//  Instruction fetch stage of the NPC core. Holds the architectural PC and issues
//  one 32-bit read per instruction to instruction memory over a valid/ready request

---
 rtl/ifu_fetch.sv | 111 +++++++++++
 tb/tb_ifu_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage, holds the PC and fetches one word per instruction
//  clk, rst_n                     clock, asynchronous active-low reset
//  req_valid/req_ready/req_addr   instruction memory read request (one outstanding)
//  rsp_valid/rsp_data/rsp_err     instruction memory response
//  out_valid/out_ready            instruction handoff to decode
//  out_pc/out_inst/out_exc        fetched pc, word, exception (01 misaligned, 10 fault)
//  redirect_valid/redirect_pc     pc redirect from execute
//  halt                           stop fetching, sticky until reset
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [1:0]  out_exc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, HALTED} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic [1:0]  exc_q, exc_d;
  logic        kill_q, kill_d, drain_q, drain_d;
  logic        mis, req_hs, out_hs;
  assign mis       = |pc_q[1:0];
  assign req_valid = state_q == REQ && !mis;
  assign req_hs    = req_valid && req_ready;
  assign out_valid = state_q == HOLD;
  assign out_hs    = out_valid && out_ready;
  assign req_addr  = pc_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;
  assign out_exc   = exc_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;
    kill_d  = kill_q;
    drain_d = drain_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ:
        if (halt) begin
          // an accepted request must still have its response drained
          state_d = req_hs ? WAIT : HALTED;
          drain_d = req_hs;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          kill_d  = req_hs;
          state_d = req_hs ? WAIT : REQ;
        end else if (mis) begin
          state_d = HOLD;
          inst_d  = NOP_INST;
          exc_d   = 2'b01;
        end else if (req_hs) state_d = WAIT;
      WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (rsp_valid) begin
          kill_d  = 1'b0;
          drain_d = 1'b0;
          state_d = (drain_q || halt) ? HALTED : (kill_q || redirect_valid) ? REQ : HOLD;
          inst_d  = rsp_data;
          exc_d   = rsp_err ? 2'b10 : 2'b00;
        end else begin
          kill_d  = kill_q || redirect_valid;
          drain_d = drain_q || halt;
        end
      end
      HOLD:
        if (out_hs && halt) state_d = HALTED;
        else if (redirect_valid || out_hs) begin
          state_d = REQ;
          pc_d    = redirect_valid ? redirect_pc : pc_q + 32'd4;
        end
      default: ;
    endcase
    // nothing valid is held outside HOLD
    if (state_d != HOLD) begin
      inst_d = NOP_INST;
      exc_d  = 2'b00;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      exc_q   <= 2'b00;
      kill_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
      kill_q  <= kill_d;
      drain_q <= drain_d;
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch with a memory model and a pc-stream scoreboard
module tb_ifu_fetch;
  localparam logic [31:0] RPC = 32'h8000_0000, NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [31:0] rsp_data = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;
  logic [1:0] out_exc;
  logic redirect_valid = 1'b0, halt = 1'b0;
  logic [31:0] redirect_pc = '0;
  int checks = 0, errors = 0;
  bit pend, ovr_en, ovr_err, saw_out, sb_en, rnd_en;
  int pcnt, lat_fix = -1, nreq = 0, ndeliv = 0;
  logic [31:0] paddr, ovr_data, exp_pc;
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );
  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  function automatic bit merr(input logic [31:0] a);
    return a[6:4] == 3'b101;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    bit rh, oh, rs, rd, hold;
    logic [31:0] ra, rdpc, op, oi, ei;
    logic [1:0] oe, ee;
    rh = req_valid && req_ready;
    oh = out_valid && out_ready;
    rs = rsp_valid;
    rd = redirect_valid;
    rdpc = redirect_pc;
    ra = req_addr;
    op = out_pc;
    oi = out_inst;
    oe = out_exc;
    hold = out_valid && !out_ready && !redirect_valid;
    if (rh) begin
      chk("one_outstanding", 32'(pend || rs), 32'd0);
      chk("req_aligned", 32'(ra[1:0]), 32'd0);
      nreq++;
    end
    if (sb_en && oh) begin
      ei = |exp_pc[1:0] ? NOP : mword(exp_pc);
      ee = |exp_pc[1:0] ? 2'b01 : merr(exp_pc) ? 2'b10 : 2'b00;
      chk("sb_pc", op, exp_pc);
      chk("sb_inst", oi, ei);
      chk("sb_exc", 32'(oe), 32'(ee));
      exp_pc += 32'd4;
      ndeliv++;
    end
    if (sb_en && rd) exp_pc = rdpc;
    @(posedge clk);
    #1;
    if (out_valid) saw_out = 1;
    if (sb_en && hold) begin
      chk("stable_valid", 32'(out_valid), 32'd1);
      chk("stable_pc", out_pc, op);
      chk("stable_inst", out_inst, oi);
      chk("stable_exc", 32'(out_exc), 32'(oe));
    end
    rsp_valid = 1'b0;
    if (rh) begin
      pend = 1;
      pcnt = lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 2));
      paddr = ra;
    end
    if (pend) begin
      if (pcnt == 0) begin
        pend = 0;
        rsp_valid = 1'b1;
        rsp_data = ovr_en ? ovr_data : mword(paddr);
        rsp_err = ovr_en ? ovr_err : merr(paddr);
        ovr_en = 0;
      end else pcnt--;
    end
    if (rnd_en) begin
      req_ready = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFF8 :
                    RPC + (32'($urandom_range(0, 255)) << 2) + ($urandom_range(0, 4) == 0 ? 32'($urandom_range(1, 3)) : 32'd0);
    end
  endtask
  task automatic wait_req(input int mx, output int n);
    n = 0;
    while (!req_valid && n < mx) begin
      cyc();
      n++;
    end
    chk("req_seen", 32'(req_valid), 32'd1);
  endtask
  task automatic wait_out(input int mx, output int n);
    n = 0;
    while (!out_valid && n < mx) begin
      cyc();
      n++;
    end
    chk("out_seen", 32'(out_valid), 32'd1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {req_ready, out_ready, redirect_valid, halt, rsp_valid} = '0;
    {rnd_en, sb_en, pend, ovr_en} = '0;
    lat_fix = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", req_addr, RPC);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, RPC);
    chk("rst_out_inst", out_inst, NOP);
    chk("rst_out_exc", 32'(out_exc), 32'd0);
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
    int          hold;
  } vec_t;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tv[5];
    int n, base;
    tv[0] = '{32'h0010_0073, 1'b0, 0, 32'h8000_0000, 32'h0010_0073, 2'b00, 0};
    tv[1] = '{32'h0050_0093, 1'b0, 1, 32'h8000_0004, 32'h0050_0093, 2'b00, 0};
    tv[2] = '{32'h00A0_0113, 1'b0, 0, 32'h8000_0008, 32'h00A0_0113, 2'b00, 0};
    tv[3] = '{32'hFFF0_0193, 1'b0, 2, 32'h8000_000C, 32'hFFF0_0193, 2'b00, 0};
    tv[4] = '{32'h0BAD_0BAD, 1'b1, 0, 32'h8000_0010, 32'h0BAD_0BAD, 2'b10, 5};
    do_reset();
    wait_req(4, n);
    chk("boot_to_req", n, 1);
    req_ready = 1'b1;
    base = nreq;
    for (int i = 0; i < 5; i++) begin
      wait_req(4, n);
      if (i > 0) chk("tv_req_next", n, 0);
      chk("tv_addr", req_addr, tv[i].pc);
      lat_fix = tv[i].lat;
      ovr_en = 1;
      ovr_data = tv[i].data;
      ovr_err = tv[i].err;
      wait_out(8, n);
      chk("tv_lat", n, 2 + tv[i].lat);
      chk("tv_pc", out_pc, tv[i].pc);
      chk("tv_inst", out_inst, tv[i].inst);
      chk("tv_exc", 32'(out_exc), 32'(tv[i].exc));
      for (int k = 0; k < tv[i].hold; k++) begin
        cyc();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_inst", out_inst, tv[i].inst);
        chk("hold_exc", 32'(out_exc), 32'(tv[i].exc));
        chk("hold_no_req", 32'(req_valid), 32'd0);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("tv_consumed", 32'(out_valid), 32'd0);
    end
    chk("tv_nreq", nreq - base, 5);
    lat_fix = 2;
    ovr_en = 1;
    ovr_data = 32'hDEAD_BEEF;
    ovr_err = 0;
    chk("t3_addr", req_addr, 32'h8000_0014);
    cyc();
    req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    saw_out = 0;
    cyc();
    redirect_valid = 1'b0;
    req_ready = 1'b1;
    wait_req(8, n);
    chk("t3_drain", n, 2);
    chk("t3_redir_addr", req_addr, 32'h8000_0100);
    chk("t3_no_out", 32'(saw_out), 32'd0);
    lat_fix = 0;
    wait_out(8, n);
    chk("t3_pc", out_pc, 32'h8000_0100);
    chk("t3_inst", out_inst, mword(32'h8000_0100));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    cyc();
    redirect_valid = 1'b0;
    chk("wr_req_valid", 32'(req_valid), 32'd1);
    chk("wr_addr", req_addr, 32'h8000_0200);
    chk("wr_no_out", 32'(out_valid), 32'd0);
    wait_out(8, n);
    chk("wr_lat", n, 2);
    chk("wr_pc", out_pc, 32'h8000_0200);
    chk("wr_inst", out_inst, mword(32'h8000_0200));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_addr", req_addr, 32'h8000_0102);
    chk("t4_no_req", 32'(req_valid), 32'd0);
    req_ready = 1'b1;
    base = nreq;
    cyc();
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_exc", 32'(out_exc), 32'd1);
    chk("t4_inst", out_inst, NOP);
    chk("t4_pc", out_pc, 32'h8000_0102);
    chk("t4_nreq", nreq - base, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    out_ready = 1'b1;
    cyc();
    {redirect_valid, out_ready} = '0;
    chk("hr_out_valid", 32'(out_valid), 32'd0);
    chk("hr_req_valid", 32'(req_valid), 32'd1);
    chk("hr_addr", req_addr, 32'h8000_0300);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0400;
    lat_fix = 0;
    base = nreq;
    cyc();
    redirect_valid = 1'b0;
    wait_out(10, n);
    chk("kill_lat", n, 3);
    chk("kill_pc", out_pc, 32'h8000_0400);
    chk("kill_inst", out_inst, mword(32'h8000_0400));
    chk("kill_nreq", nreq - base, 2);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    wait_out(8, n);
    chk("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_top", out_inst, mword(32'hFFFF_FFFC));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("wrap_addr", req_addr, 32'h0);
    wait_out(8, n);
    chk("wrap_pc_zero", out_pc, 32'h0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    lat_fix = 2;
    base = nreq;
    cyc();
    req_ready = 1'b0;
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    saw_out = 0;
    repeat (6) cyc();
    chk("t6_halted_req", 32'(req_valid), 32'd0);
    req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0500;
    cyc();
    redirect_valid = 1'b0;
    repeat (4) cyc();
    chk("t6_nreq", nreq - base, 1);
    chk("t6_no_out", 32'(saw_out), 32'd0);
    chk("t6_sticky_req", 32'(req_valid), 32'd0);
    chk("t6_sticky_out", 32'(out_valid), 32'd0);
    do_reset();
    rsp_valid = 1'b1;
    rsp_data = 32'hBAAD_F00D;
    rsp_err = 1'b1;
    cyc();
    chk("boot_rsp_req", 32'(req_valid), 32'd1);
    chk("boot_rsp_out", 32'(out_valid), 32'd0);
    chk("boot_rsp_addr", req_addr, RPC);
    lat_fix = 0;
    req_ready = 1'b1;
    wait_out(6, n);
    chk("boot_lat", n, 2);
    chk("boot_pc", out_pc, RPC);
    chk("boot_inst", out_inst, mword(RPC));
    chk("boot_exc", 32'(out_exc), 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    wait_out(6, n);
    chk("pre_arst_pc", out_pc, 32'h8000_0004);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_req_valid", 32'(req_valid), 32'd0);
    chk("arst_out_pc", out_pc, RPC);
    chk("arst_out_inst", out_inst, NOP);
    do_reset();
    req_ready = 1'b1;
    lat_fix = 0;
    wait_out(8, n);
    halt = 1'b1;
    out_ready = 1'b1;
    cyc();
    {halt, out_ready} = '0;
    chk("hh_out_valid", 32'(out_valid), 32'd0);
    chk("hh_req_valid", 32'(req_valid), 32'd0);
    base = nreq;
    repeat (4) cyc();
    chk("hh_nreq", nreq - base, 0);
    do_reset();
    exp_pc = RPC;
    ndeliv = 0;
    sb_en = 1;
    cyc();
    rnd_en = 1;
    repeat (3000) cyc();
    {rnd_en, sb_en} = '0;
    chk("rnd_progress", 32'(ndeliv > 100), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
